// File: rtl/gpio_debounce_pkg.sv
// Shared constants and helpers for the GPIO debounce block.
// The SoC-facing GPIO width and the default debounce length live here.
package gpio_debounce_pkg;

  localparam int GPIO_WIDTH    = 8;
  localparam int DB_CYCLES_DEF = 16;

  // Counter must be able to hold the values 0..DB_CYCLES.
  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_db_cell.sv
// One debounced GPIO channel: 2-flop synchronizer, stability counter,
// accepted level register and registered rise/fall pulses.
module gpio_db_cell
  import gpio_debounce_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEF,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = r_sync_p1 ^ r_level;
  assign w_accept = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_p0 <= RESET_BIT;
      r_sync_p1 <= RESET_BIT;
      r_cnt     <= '0;
      r_level   <= RESET_BIT;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync_p0 <= pin_i;
      r_sync_p1 <= r_sync_p0;
      // Any return to the accepted level throws away the partial count.
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_level <= r_level ^ w_accept;
      r_rise  <= w_accept & ~r_level;
      r_fall  <= w_accept &  r_level;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: rtl/gpio_debounce.sv
// Multi-channel GPIO debouncer with per-bit edge-selectable sticky
// interrupt pending flags and a combined IRQ line for the CPU.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int               WIDTH     = GPIO_WIDTH,
  parameter int               DB_CYCLES = DB_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_i,
  input  logic [WIDTH-1:0] edge_sel_i,
  input  logic [WIDTH-1:0] irq_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] r_pending;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    gpio_db_cell #(
      .DB_CYCLES (DB_CYCLES),
      .RESET_BIT (RESET_VAL[g])
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (pins_i[g]),
      .level_o (w_level[g]),
      .rise_o  (w_rise[g]),
      .fall_o  (w_fall[g])
    );
  end

  assign w_set = irq_en_i & ((edge_sel_i & w_rise) | (~edge_sel_i & w_fall));

  // A new event in the same cycle as a clear wins, so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_set | (r_pending & ~irq_clr_i);
    end
  end

  assign level_o   = w_level;
  assign rise_o    = w_rise;
  assign fall_o    = w_fall;
  assign pending_o = r_pending;
  assign irq_o     = |r_pending;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed pin sequences queue cycle-tagged
// expectations that a negedge monitor compares against the DUT outputs.
module tb_gpio_debounce;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pins_i;
  logic [W-1:0] edge_sel_i;
  logic [W-1:0] irq_en_i;
  logic [W-1:0] irq_clr_i;
  logic [W-1:0] level_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] pending_o;
  logic         irq_o;

  gpio_debounce #(
    .WIDTH     (W),
    .DB_CYCLES (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pins_i     (pins_i),
    .edge_sel_i (edge_sel_i),
    .irq_en_i   (irq_en_i),
    .irq_clr_i  (irq_clr_i),
    .level_o    (level_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .pending_o  (pending_o),
    .irq_o      (irq_o)
  );

  localparam int K_LEVEL = 0;
  localparam int K_RISE  = 1;
  localparam int K_FALL  = 2;
  localparam int K_PEND  = 3;
  localparam int K_IRQ   = 4;

  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   now;

  initial clk = 1'b0;
  always #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_LEVEL: return "level_o";
      K_RISE:  return "rise_o";
      K_FALL:  return "fall_o";
      K_PEND:  return "pending_o";
      default: return "irq_o";
    endcase
  endfunction

  function automatic logic [W-1:0] actual(input int k);
    case (k)
      K_LEVEL: return level_o;
      K_RISE:  return rise_o;
      K_FALL:  return fall_o;
      K_PEND:  return pending_o;
      default: return {{(W-1){1'b0}}, irq_o};
    endcase
  endfunction

  function automatic void check(input string nm, input int c,
                                input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, c, act, exp);
    end
  endfunction

  function automatic void exp_at(input int c, input int k, input logic [W-1:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        check(kname(q[i].kind), cyc, actual(q[i].kind), q[i].val);
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed cycle %0d", kname(q[i].kind), q[i].cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    pins_i     = '0;
    edge_sel_i = '0;
    irq_en_i   = '0;
    irq_clr_i  = '0;
    wait_cyc(3);
    now = cyc;
    for (int k = 1; k <= 2; k++) begin
      exp_at(now + k, K_LEVEL, 8'h00);
      exp_at(now + k, K_RISE,  8'h00);
      exp_at(now + k, K_FALL,  8'h00);
      exp_at(now + k, K_PEND,  8'h00);
      exp_at(now + k, K_IRQ,   8'h00);
    end
    wait_cyc(2);

    // Quiet after reset release
    reset_n = 1'b1;
    now = cyc;
    for (int k = 1; k <= 20; k++) begin
      exp_at(now + k, K_LEVEL, 8'h00);
      exp_at(now + k, K_RISE,  8'h00);
      exp_at(now + k, K_FALL,  8'h00);
      exp_at(now + k, K_IRQ,   8'h00);
    end
    wait_cyc(21);

    // Bit 0 rises: level exactly 6 edges later with a one-cycle rise pulse
    pins_i = 8'h01;
    now = cyc;
    exp_at(now + 5, K_LEVEL, 8'h00);
    exp_at(now + 6, K_LEVEL, 8'h01);
    exp_at(now + 5, K_RISE,  8'h00);
    exp_at(now + 6, K_RISE,  8'h01);
    exp_at(now + 7, K_RISE,  8'h00);
    exp_at(now + 6, K_FALL,  8'h00);
    exp_at(now + 7, K_FALL,  8'h00);
    exp_at(now + 7, K_PEND,  8'h00);
    wait_cyc(10);

    // Bit 3 glitches of 1 and 3 cycles are rejected
    now = cyc;
    for (int k = 1; k <= 16; k++) begin
      exp_at(now + k, K_LEVEL, 8'h01);
      exp_at(now + k, K_RISE,  8'h00);
      exp_at(now + k, K_FALL,  8'h00);
      exp_at(now + k, K_PEND,  8'h00);
    end
    pins_i = 8'h09;
    wait_cyc(1);
    pins_i = 8'h01;
    wait_cyc(3);
    pins_i = 8'h09;
    wait_cyc(3);
    pins_i = 8'h01;
    wait_cyc(12);

    // Rising-edge interrupt on bit 0; a fall must not set pending
    irq_en_i   = 8'h01;
    edge_sel_i = 8'h01;
    pins_i     = 8'h00;
    now = cyc;
    exp_at(now + 6, K_LEVEL, 8'h00);
    exp_at(now + 6, K_FALL,  8'h01);
    exp_at(now + 7, K_PEND,  8'h00);
    wait_cyc(10);
    pins_i = 8'h01;
    now = cyc;
    exp_at(now + 6, K_RISE, 8'h01);
    exp_at(now + 6, K_PEND, 8'h00);
    exp_at(now + 7, K_PEND, 8'h01);
    exp_at(now + 7, K_IRQ,  8'h01);
    wait_cyc(9);
    irq_clr_i = 8'h01;
    now = cyc;
    exp_at(now + 1, K_PEND, 8'h00);
    exp_at(now + 1, K_IRQ,  8'h00);
    wait_cyc(1);
    irq_clr_i = 8'h00;
    wait_cyc(3);
    pins_i = 8'h00;
    now = cyc;
    exp_at(now + 6, K_FALL, 8'h01);
    exp_at(now + 7, K_PEND, 8'h00);
    wait_cyc(10);

    // Clear coincident with a new rise leaves pending set
    pins_i = 8'h01;
    now = cyc;
    exp_at(now + 6, K_RISE, 8'h01);
    exp_at(now + 7, K_PEND, 8'h01);
    exp_at(now + 8, K_PEND, 8'h01);
    exp_at(now + 8, K_IRQ,  8'h01);
    wait_cyc(6);
    irq_clr_i = 8'h01;
    wait_cyc(1);
    irq_clr_i = 8'h00;
    wait_cyc(3);
    irq_clr_i = 8'h01;
    now = cyc;
    exp_at(now + 1, K_PEND, 8'h00);
    wait_cyc(1);
    irq_clr_i = 8'h00;
    wait_cyc(2);

    // All bits together, falling-edge interrupts
    irq_en_i = 8'h00;
    pins_i   = 8'h00;
    wait_cyc(10);
    irq_en_i   = 8'hFF;
    edge_sel_i = 8'h00;
    pins_i     = 8'hFF;
    now = cyc;
    exp_at(now + 5, K_LEVEL, 8'h00);
    exp_at(now + 6, K_LEVEL, 8'hFF);
    exp_at(now + 6, K_RISE,  8'hFF);
    exp_at(now + 7, K_RISE,  8'h00);
    exp_at(now + 7, K_PEND,  8'h00);
    wait_cyc(10);
    pins_i = 8'h00;
    now = cyc;
    exp_at(now + 6, K_LEVEL, 8'h00);
    exp_at(now + 6, K_FALL,  8'hFF);
    exp_at(now + 7, K_FALL,  8'h00);
    exp_at(now + 6, K_RISE,  8'h00);
    exp_at(now + 6, K_PEND,  8'h00);
    exp_at(now + 7, K_PEND,  8'hFF);
    exp_at(now + 7, K_IRQ,   8'h01);
    wait_cyc(10);
    irq_clr_i = 8'hFF;
    now = cyc;
    exp_at(now + 1, K_PEND, 8'h00);
    exp_at(now + 1, K_IRQ,  8'h00);
    wait_cyc(1);
    irq_clr_i = 8'h00;
    wait_cyc(2);

    // Reset in the middle of a count
    edge_sel_i = 8'hFF;
    pins_i     = 8'hFF;
    now = cyc;
    exp_at(now + 6, K_LEVEL, 8'hFF);
    exp_at(now + 7, K_PEND,  8'hFF);
    wait_cyc(10);
    pins_i = 8'h7F;
    now = cyc;
    exp_at(now + 4, K_LEVEL, 8'hFF);
    exp_at(now + 4, K_PEND,  8'hFF);
    wait_cyc(4);
    #1 reset_n = 1'b0;
    #1;
    check("async_level",   cyc, level_o,   8'h00);
    check("async_pending", cyc, pending_o, 8'h00);
    check("async_irq",     cyc, {7'b0, irq_o}, 8'h00);
    check("async_rise",    cyc, rise_o,    8'h00);
    wait_cyc(2);
    reset_n = 1'b1;
    now = cyc;
    for (int k = 1; k <= 5; k++) begin
      exp_at(now + k, K_LEVEL, 8'h00);
      exp_at(now + k, K_RISE,  8'h00);
    end
    for (int k = 1; k <= 6; k++) exp_at(now + k, K_PEND, 8'h00);
    exp_at(now + 6, K_LEVEL, 8'h7F);
    exp_at(now + 6, K_RISE,  8'h7F);
    exp_at(now + 7, K_PEND,  8'h7F);
    wait_cyc(10);

    for (int k = 0; k < 20 && q.size() != 0; k++) wait_cyc(1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
